// File: rtl/ov7670_pkg.sv
// Shared OV7670 register map constants and the test-mode updater state encoding.
package ov7670_pkg;

    localparam logic [7:0] OV_REG_COM7  = 8'h12;
    localparam logic [7:0] OV_REG_COM17 = 8'h42;

    localparam int COM7_CBAR  = 1;
    localparam int COM17_CBAR = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT_LO = 3'd2,
        ST_WAIT_HI = 3'd3,
        ST_SETTLE  = 3'd4
    } tm_state_t;

endpackage

// File: rtl/ov7670_tm_cfg.sv
// Rewrites the OV7670 colour-bar registers (COM17 then COM7) over SCCB whenever the
// requested test mode differs from the programmed one, then waits a settle delay.
module ov7670_tm_cfg
    import ov7670_pkg::*;
#(
    parameter logic [7:0]  C_COM7_BASE  = 8'h00,
    parameter logic [7:0]  C_COM17_BASE = 8'h00,
    parameter int unsigned C_SETTLE_CYC = 1_600_000,
    parameter int          C_SETTLE_W   = 21
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       test_mode,
    input  logic       init_done,
    input  logic       sccb_ready,
    output logic       sccb_start,
    output logic [7:0] sccb_addr,
    output logic [7:0] sccb_data,
    output logic       busy,
    output logic       test_mode_applied
);

    localparam logic [C_SETTLE_W-1:0] SETTLE_LOAD = C_SETTLE_W'(C_SETTLE_CYC - 1);

    tm_state_t             state;
    logic                  idx;
    logic                  target;
    logic [C_SETTLE_W-1:0] settle_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= ST_IDLE;
            idx               <= 1'b0;
            target            <= 1'b0;
            settle_cnt        <= '0;
            sccb_start        <= 1'b0;
            sccb_addr         <= 8'h00;
            sccb_data         <= 8'h00;
            busy              <= 1'b0;
            test_mode_applied <= 1'b0;
        end else begin
            sccb_start <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    // test_mode is only sampled here, so mid-sequence changes wait their turn
                    if (init_done && (test_mode != test_mode_applied)) begin
                        target <= test_mode;
                        idx    <= 1'b0;
                        busy   <= 1'b1;
                        state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (sccb_ready) begin
                        sccb_start <= 1'b1;
                        if (!idx) begin
                            sccb_addr <= OV_REG_COM17;
                            sccb_data <= C_COM17_BASE | (8'(target) << COM17_CBAR);
                        end else begin
                            sccb_addr <= OV_REG_COM7;
                            sccb_data <= C_COM7_BASE | (8'(target) << COM7_CBAR);
                        end
                        state <= ST_WAIT_LO;
                    end
                end
                ST_WAIT_LO: begin
                    if (!sccb_ready) state <= ST_WAIT_HI;
                end
                ST_WAIT_HI: begin
                    if (sccb_ready) begin
                        if (!idx) begin
                            idx   <= 1'b1;
                            state <= ST_ISSUE;
                        end else begin
                            settle_cnt <= SETTLE_LOAD;
                            state      <= ST_SETTLE;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == '0) begin
                        test_mode_applied <= target;
                        busy              <= 1'b0;
                        state             <= ST_IDLE;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ov7670_tm_cfg.sv
// Scoreboard bench for ov7670_tm_cfg with a simple SCCB master model.
module tb_ov7670_tm_cfg;

    localparam int SETTLE = 100;
    localparam int BUDGET = 2000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       test_mode = 1'b0;
    logic       init_done = 1'b0;
    logic       sccb_ready = 1'b1;
    logic       sccb_start;
    logic [7:0] sccb_addr;
    logic [7:0] sccb_data;
    logic       busy;
    logic       test_mode_applied;

    int n_checks  = 0;
    int n_fail    = 0;
    int start_cnt = 0;
    int pcyc      = 0;
    int rise_pcyc = 0;
    int low_cnt   = 0;
    logic [15:0] exp_q[$];

    ov7670_tm_cfg #(
        .C_COM7_BASE (8'h00),
        .C_COM17_BASE(8'h00),
        .C_SETTLE_CYC(SETTLE),
        .C_SETTLE_W  (8)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .test_mode        (test_mode),
        .init_done        (init_done),
        .sccb_ready       (sccb_ready),
        .sccb_start       (sccb_start),
        .sccb_addr        (sccb_addr),
        .sccb_data        (sccb_data),
        .busy             (busy),
        .test_mode_applied(test_mode_applied)
    );

    always #5 clk = ~clk;
    always @(posedge clk) pcyc <= pcyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // SCCB master: ready drops after a start and stays low for 50 cycles
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            sccb_ready = 1'b1;
            low_cnt    = 0;
        end else if (sccb_start) begin
            sccb_ready = 1'b0;
            low_cnt    = 50;
        end else if (low_cnt > 0) begin
            low_cnt--;
            if (low_cnt == 0) begin
                sccb_ready = 1'b1;
                rise_pcyc  = pcyc;
            end
        end
    end

    // Monitor: every write strobe is matched against the next expected (addr,data)
    initial forever begin
        @(negedge clk);
        if (rst && sccb_start) begin
            start_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got %0h expected none", {sccb_addr, sccb_data});
            end else begin
                check("write", {sccb_addr, sccb_data}, exp_q.pop_front());
            end
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_applied(input logic v, input string name);
        int n = 0;
        while (test_mode_applied !== v && n < BUDGET) begin
            tick();
            n++;
        end
        check(name, test_mode_applied, v);
    endtask

    task automatic wait_starts(input int cnt, input string name);
        int n = 0;
        while (start_cnt < cnt && n < BUDGET) begin
            tick();
            n++;
        end
        check(name, start_cnt >= cnt, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0;
        int applied_pcyc;
        int busy_drops;
        int n;

        // 1: reset state, then no writes while init_done is low
        test_mode = 1'b1;
        tick(3);
        check("rst_start", sccb_start, 0);
        check("rst_addr", sccb_addr, 0);
        check("rst_data", sccb_data, 0);
        check("rst_busy", busy, 0);
        check("rst_applied", test_mode_applied, 0);
        rst = 1'b1;
        tick(20);
        check("no_init_starts", start_cnt, 0);
        check("no_init_busy", busy, 0);

        // 2: enter colour bar; applied rises SETTLE edges after the DUT samples ready high
        exp_q.push_back(16'h4208);
        exp_q.push_back(16'h1202);
        init_done = 1'b1;
        wait_applied(1'b1, "t2_applied");
        applied_pcyc = pcyc;
        check("t2_settle_time", applied_pcyc - rise_pcyc, SETTLE + 1);
        check("t2_busy_clear", busy, 0);
        check("t2_starts", start_cnt, 2);

        // 3: back to normal mode, busy held for the whole sequence
        exp_q.push_back(16'h4200);
        exp_q.push_back(16'h1200);
        test_mode = 1'b0;
        tick();
        check("t3_busy_set", busy, 1);
        busy_drops = 0;
        n = 0;
        while (test_mode_applied !== 1'b0 && n < BUDGET) begin
            if (!busy) busy_drops++;
            tick();
            n++;
        end
        check("t3_applied", test_mode_applied, 0);
        check("t3_busy_drops", busy_drops, 0);

        // 4: toggles during the sequence are not acted on separately
        s0 = start_cnt;
        exp_q.push_back(16'h4208);
        exp_q.push_back(16'h1202);
        test_mode = 1'b1;
        wait_starts(s0 + 1, "t4_first_start");
        test_mode = 1'b0;
        tick();
        test_mode = 1'b1;
        tick();
        test_mode = 1'b0;
        tick();
        test_mode = 1'b1;
        wait_applied(1'b1, "t4_applied");
        tick(20);
        check("t4_starts", start_cnt - s0, 2);
        check("t4_idle", busy, 0);

        // 5: return to 0 during SETTLE triggers a second sequence
        exp_q.push_back(16'h4200);
        exp_q.push_back(16'h1200);
        test_mode = 1'b0;
        wait_applied(1'b0, "t5_pre_applied");
        s0 = start_cnt;
        exp_q.push_back(16'h4208);
        exp_q.push_back(16'h1202);
        exp_q.push_back(16'h4200);
        exp_q.push_back(16'h1200);
        test_mode = 1'b1;
        wait_starts(s0 + 2, "t5_second_start");
        tick(60);
        check("t5_in_settle_busy", busy, 1);
        check("t5_in_settle_applied", test_mode_applied, 0);
        test_mode = 1'b0;
        wait_applied(1'b1, "t5_applied_hi");
        wait_applied(1'b0, "t5_applied_lo");
        check("t5_starts", start_cnt - s0, 4);

        // 6: reset while waiting for the first write to finish
        s0 = start_cnt;
        exp_q.push_back(16'h4208);
        test_mode = 1'b1;
        wait_starts(s0 + 1, "t6_first_start");
        tick(10);
        check("t6_pre_busy", busy, 1);
        rst = 1'b0;
        tick();
        check("t6_rst_busy", busy, 0);
        check("t6_rst_start", sccb_start, 0);
        check("t6_rst_applied", test_mode_applied, 0);
        tick(2);
        exp_q.push_back(16'h4208);
        exp_q.push_back(16'h1202);
        rst = 1'b1;
        wait_applied(1'b1, "t6_applied");
        check("t6_starts", start_cnt - s0, 3);

        tick(5);
        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
